// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and widths for the generic pipeline stage register.
package pipe_pkg;

  // Occupancy of a stage: EMPTY holds nothing, ONE holds the output entry,
  // TWO also holds a younger entry in the skid slot.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int OCC_W = 2;

  // Standard stage bundle widths so every stage instance agrees on them.
  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 165;
  localparam int EX_MEM_CTRL_W = 12;
  localparam int EX_MEM_DATA_W = 106;
  localparam int MEM_WB_CTRL_W = 6;
  localparam int MEM_WB_DATA_W = 69;

  typedef logic [IF_ID_CTRL_W-1:0]  if_id_ctrl_t;
  typedef logic [IF_ID_DATA_W-1:0]  if_id_data_t;
  typedef logic [ID_EX_CTRL_W-1:0]  id_ex_ctrl_t;
  typedef logic [ID_EX_DATA_W-1:0]  id_ex_data_t;
  typedef logic [EX_MEM_CTRL_W-1:0] ex_mem_ctrl_t;
  typedef logic [EX_MEM_DATA_W-1:0] ex_mem_data_t;
  typedef logic [MEM_WB_CTRL_W-1:0] mem_wb_ctrl_t;
  typedef logic [MEM_WB_DATA_W-1:0] mem_wb_data_t;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One register entry of a pipeline stage: valid flag, control and data.
// Clear wins over load; control is always zero while the entry is invalid.
module pipe_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 165
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_clr_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              vld_q,  vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next entry: invalidate (optionally wiping data), load a new entry, or hold.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (i_clr) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
      if (i_clr_data) begin
        data_d = '0;
      end
    end else if (i_load) begin
      vld_d  = 1'b1;
      ctrl_d = i_ctrl;
      data_d = i_data;
    end
  end

  // Entry storage; reset clears everything including data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign o_vld  = vld_q;
  assign o_ctrl = ctrl_q;
  assign o_data = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, stall, flush
// and an optional 2-entry skid buffer that registers the upstream ready.
// The main slot always drives the output; the skid slot holds the younger entry.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 165,
  parameter int SKID_EN  = 1,
  parameter int CLR_DATA = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_up_vld,
  output logic              o_up_rdy,
  input  logic [CTRL_W-1:0] i_up_ctrl,
  input  logic [DATA_W-1:0] i_up_data,
  output logic              o_dn_vld,
  input  logic              i_dn_rdy,
  output logic [CTRL_W-1:0] o_dn_ctrl,
  output logic [DATA_W-1:0] o_dn_data,
  output logic [OCC_W-1:0]  o_occ
);

  pipe_state_e state_q, state_d;
  logic        up_rdy_q;

  logic        up_xfer;
  logic        dn_xfer;
  logic        rdy_comb;
  logic        flush_clr_data;

  logic        main_load;
  logic        main_clr;
  logic        main_sel_skid;
  logic        skid_load;
  logic        skid_clr;

  logic              main_vld;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign rdy_comb       = (state_q == EMPTY) | i_dn_rdy;
  assign o_up_rdy       = ~i_rst & ((SKID_EN != 0) ? up_rdy_q : rdy_comb);
  assign up_xfer        = i_up_vld & o_up_rdy;
  assign dn_xfer        = main_vld & i_dn_rdy;
  assign flush_clr_data = i_flush && (CLR_DATA != 0);

  // Next state and slot controls; flush overrides any transfer into the stage.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_load = 1'b1;
        end else if (up_xfer && (SKID_EN != 0)) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (dn_xfer) begin
          main_clr = 1'b1;
          state_d  = EMPTY;
        end
      end
      TWO: begin
        if (i_dn_rdy) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_clr      = 1'b1;
          state_d       = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (i_flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  // State register plus the registered upstream ready used in skid mode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= EMPTY;
      up_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      up_rdy_q <= (state_d != TWO);
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (main_load),
    .i_clr      (main_clr),
    .i_clr_data (flush_clr_data),
    .i_ctrl     (main_sel_skid ? skid_ctrl : i_up_ctrl),
    .i_data     (main_sel_skid ? skid_data : i_up_data),
    .o_vld      (main_vld),
    .o_ctrl     (main_ctrl),
    .o_data     (main_data)
  );

  if (SKID_EN != 0) begin : g_skid
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (skid_load),
      .i_clr      (skid_clr),
      .i_clr_data (flush_clr_data),
      .i_ctrl     (i_up_ctrl),
      .i_data     (i_up_data),
      .o_vld      (skid_vld),
      .o_ctrl     (skid_ctrl),
      .o_data     (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid_ctrl;
    assign unused_skid_ctrl = ^{skid_load, skid_clr, skid_vld};
    assign skid_vld  = 1'b0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  assign o_dn_vld  = main_vld;
  assign o_dn_ctrl = main_vld ? main_ctrl : '0;
  assign o_dn_data = main_data;
  assign o_occ     = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: three stage instances (skid+clear, no skid, skid+keep data)
// share one stimulus stream and are each compared to a FIFO-style model.
module tb_pipe_stage_buf;

  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NI = 3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst, flush, upVld, dnRdy;
  logic [CW-1:0] upCtrl;
  logic [DW-1:0] upData;

  logic [NI-1:0] upRdy, dnVld;
  logic [CW-1:0] dnCtrl [NI];
  logic [DW-1:0] dnData [NI];
  logic [1:0]    occ    [NI];

  int checks   = 0;
  int failures = 0;

  int skidCfg [NI] = '{1, 0, 1};
  int clrCfg  [NI] = '{1, 1, 0};

  entry_t        mq     [NI][2];
  int            mcnt   [NI];
  bit            mKnown [NI];
  logic [DW-1:0] mIdle  [NI];

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CLR_DATA(1)) dutSkid (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up_vld(upVld), .o_up_rdy(upRdy[0]),
    .i_up_ctrl(upCtrl), .i_up_data(upData), .o_dn_vld(dnVld[0]), .i_dn_rdy(dnRdy),
    .o_dn_ctrl(dnCtrl[0]), .o_dn_data(dnData[0]), .o_occ(occ[0]));

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CLR_DATA(1)) dutNoSkid (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up_vld(upVld), .o_up_rdy(upRdy[1]),
    .i_up_ctrl(upCtrl), .i_up_data(upData), .o_dn_vld(dnVld[1]), .i_dn_rdy(dnRdy),
    .o_dn_ctrl(dnCtrl[1]), .o_dn_data(dnData[1]), .o_occ(occ[1]));

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CLR_DATA(0)) dutKeep (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up_vld(upVld), .o_up_rdy(upRdy[2]),
    .i_up_ctrl(upCtrl), .i_up_data(upData), .o_dn_vld(dnVld[2]), .i_dn_rdy(dnRdy),
    .o_dn_ctrl(dnCtrl[2]), .o_dn_data(dnData[2]), .o_occ(occ[2]));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Upstream ready: skid stage is ready unless it holds two entries; the
  // plain stage is ready when empty or when downstream takes this cycle.
  function automatic logic expRdy(input int i);
    if (rst) return 1'b0;
    if (skidCfg[i] != 0) return (mcnt[i] < 2);
    return (mcnt[i] == 0) || dnRdy;
  endfunction

  function automatic void modelStep(input int i);
    logic up, dn;
    if (rst) begin
      mcnt[i]   = 0;
      mKnown[i] = 1'b1;
      mIdle[i]  = '0;
      return;
    end
    up = upVld & expRdy(i);
    dn = (mcnt[i] > 0) & dnRdy;
    if (flush) begin
      if (clrCfg[i] != 0) begin
        mKnown[i] = 1'b1;
        mIdle[i]  = '0;
      end else if (mcnt[i] > 0) begin
        mKnown[i] = 1'b1;
        mIdle[i]  = mq[i][0].data;
      end
      mcnt[i] = 0;
    end else begin
      if (dn) begin
        mq[i][0] = mq[i][1];
        mcnt[i]--;
        if (mcnt[i] == 0) mKnown[i] = 1'b0;
      end
      if (up) begin
        mq[i][mcnt[i]] = '{ctrl: upCtrl, data: upData};
        mcnt[i]++;
      end
    end
  endfunction

  task automatic compareModel(input int i);
    checkOutput($sformatf("upRdy%0d", i), 64'(upRdy[i]), 64'(expRdy(i)));
    checkOutput($sformatf("dnVld%0d", i), 64'(dnVld[i]), 64'(mcnt[i] > 0));
    checkOutput($sformatf("occ%0d", i), 64'(occ[i]), 64'(mcnt[i]));
    checkOutput($sformatf("dnCtrl%0d", i), 64'(dnCtrl[i]),
                (mcnt[i] > 0) ? 64'(mq[i][0].ctrl) : 64'd0);
    if (mcnt[i] > 0) begin
      checkOutput($sformatf("dnData%0d", i), 64'(dnData[i]), 64'(mq[i][0].data));
    end else if (mKnown[i]) begin
      checkOutput($sformatf("idleData%0d", i), 64'(dnData[i]), 64'(mIdle[i]));
    end
  endtask

  // Drive one cycle of inputs away from the edge, check all instances, then
  // advance every model across the rising edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic dr);
    @(negedge clk);
    rst = r; flush = f; upVld = v; upCtrl = c; upData = d; dnRdy = dr;
    #1;
    for (int i = 0; i < NI; i++) compareModel(i);
    @(posedge clk);
    for (int i = 0; i < NI; i++) modelStep(i);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; upVld = 1'b1; upCtrl = 16'hFFFF; upData = 32'h1234_5678; dnRdy = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mcnt[i] = 0; mKnown[i] = 1'b0; mIdle[i] = '0;
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) modelStep(i);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 32'h1234_5678, 1'b1);

    // Streaming 1..8 back to back.
    for (int k = 1; k <= 8; k++) applyStimulus(1'b0, 1'b0, 1'b1, CW'(k + 16'h0100), DW'(k), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Backpressure: A, B then further offers while stalled, then drain.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0011, 32'h0000_00AA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0022, 32'h0000_00BB, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0033, 32'h0000_00CC, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0033, 32'h0000_00CC, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Flush while full, with a same-cycle offer that must be dropped.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00A5, 32'h0000_0A01, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00A5, 32'h0000_0A02, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00A5, 32'h0000_0C0C, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Flush holding DEAD: data survives only where data clearing is off.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001, 32'h0000_DEAD, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Toggle downstream ready 1,0,1 while streaming.
    for (int k = 0; k < 12; k++)
      applyStimulus(1'b0, 1'b0, 1'b1, CW'(16'h0200 + k), DW'(32'h100 + k), (k % 3) != 1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Randomised traffic with occasional flush and reset.
    for (int k = 0; k < 800; k++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0,
                    CW'($urandom()),
                    DW'($urandom()),
                    $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
